// File: rtl/axi4_lite_slave_if.sv
// AXI4-Lite bus bundle between one master and one responder.
// Signal names follow the standard S_AXI_* naming used by the responder.
interface axi4_lite_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
  logic                  S_AXI_AWVALID;
  logic                  S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0] S_AXI_WDATA;
  logic [STRB_WIDTH-1:0] S_AXI_WSTRB;
  logic                  S_AXI_WVALID;
  logic                  S_AXI_WREADY;
  logic [1:0]            S_AXI_BRESP;
  logic                  S_AXI_BVALID;
  logic                  S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic                  S_AXI_ARVALID;
  logic                  S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0] S_AXI_RDATA;
  logic [1:0]            S_AXI_RRESP;
  logic                  S_AXI_RVALID;
  logic                  S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, input S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, input S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID, output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARVALID, input S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID, input S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARVALID, output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, input S_AXI_RREADY
  );
endinterface

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite responder bridging AW/W/B and AR/R onto a native wr_*/rd_* register port.
// Write and read paths are independent state machines with one transaction in flight each.
module axi4_lite_slave #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           SIZE_BYTES = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  axi4_lite_slave_if.slave           s_axi,
  output logic                       wr_en,
  output logic [ADDR_WIDTH-1:0]      wr_addr,
  output logic [DATA_WIDTH-1:0]      wr_data,
  output logic [DATA_WIDTH/8-1:0]    wr_strobe,
  output logic                       rd_en,
  output logic [ADDR_WIDTH-1:0]      rd_addr,
  input  logic [DATA_WIDTH-1:0]      rd_data
);
  localparam int unsigned           STRB_WIDTH  = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] WINDOW_SIZE = ADDR_WIDTH'(SIZE_BYTES);
  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} rstate_e;

  wstate_e                wstate_q;
  logic                   aw_held_q, w_held_q, aw_ok_q;
  logic                   awready_q, wready_q;
  logic                   wr_en_q;
  logic [ADDR_WIDTH-1:0]  wr_addr_q;
  logic [DATA_WIDTH-1:0]  wr_data_q;
  logic [STRB_WIDTH-1:0]  wr_strobe_q;
  logic                   bvalid_q;
  logic [1:0]             bresp_q;

  rstate_e                rstate_q;
  logic                   arready_q;
  logic                   rd_en_q;
  logic                   rd_err_q;
  logic [ADDR_WIDTH-1:0]  rd_addr_q;
  logic                   rvalid_q;
  logic [1:0]             rresp_q;
  logic [DATA_WIDTH-1:0]  rdata_q;

  logic                   aw_hs, w_hs, ar_hs;
  logic [ADDR_WIDTH-1:0]  aw_off, ar_off;
  logic                   aw_in_range, ar_in_range;
  logic                   aw_held_d, w_held_d, aw_ok_d;

  // Handshake detection and window decode; the offset wraps high for addresses below BASE_ADDR.
  always_comb begin
    aw_hs       = s_axi.S_AXI_AWVALID && awready_q;
    w_hs        = s_axi.S_AXI_WVALID  && wready_q;
    ar_hs       = s_axi.S_AXI_ARVALID && arready_q;
    aw_off      = s_axi.S_AXI_AWADDR - BASE_ADDR;
    ar_off      = s_axi.S_AXI_ARADDR - BASE_ADDR;
    aw_in_range = (aw_off < WINDOW_SIZE);
    ar_in_range = (ar_off < WINDOW_SIZE);
    aw_held_d   = aw_held_q || aw_hs;
    w_held_d    = w_held_q  || w_hs;
    aw_ok_d     = aw_hs ? aw_in_range : aw_ok_q;
  end

  // Write path: collect AW and W in any order, pulse wr_en once, then hold B until accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wstate_q    <= W_IDLE;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      aw_ok_q     <= 1'b0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_strobe_q <= '0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
    end else begin
      wr_en_q <= 1'b0;
      case (wstate_q)
        W_IDLE: begin
          if (aw_hs) begin
            aw_held_q <= 1'b1;
            aw_ok_q   <= aw_in_range;
            wr_addr_q <= {aw_off[ADDR_WIDTH-1:2], 2'b00};
          end
          if (w_hs) begin
            w_held_q    <= 1'b1;
            wr_data_q   <= s_axi.S_AXI_WDATA;
            wr_strobe_q <= s_axi.S_AXI_WSTRB;
          end
          awready_q <= !aw_held_d;
          wready_q  <= !w_held_d;
          if (aw_held_d && w_held_d) begin
            wstate_q <= W_EXEC;
            wr_en_q  <= aw_ok_d;
            bresp_q  <= aw_ok_d ? RESP_OKAY : RESP_SLVERR;
          end
        end
        W_EXEC: begin
          bvalid_q <= 1'b1;
          wstate_q <= W_RESP;
        end
        W_RESP: begin
          if (s_axi.S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // Read path: issue rd_en, capture rd_data one cycle later, then hold R until accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_err_q  <= 1'b0;
      rd_addr_q <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      rd_en_q <= 1'b0;
      case (rstate_q)
        R_IDLE: begin
          arready_q <= !ar_hs;
          if (ar_hs) begin
            rd_en_q   <= ar_in_range;
            rd_err_q  <= !ar_in_range;
            rd_addr_q <= {ar_off[ADDR_WIDTH-1:2], 2'b00};
            rstate_q  <= R_ISSUE;
          end
        end
        R_ISSUE: rstate_q <= R_WAIT;
        R_WAIT: begin
          rdata_q  <= rd_err_q ? '0 : rd_data;
          rresp_q  <= rd_err_q ? RESP_SLVERR : RESP_OKAY;
          rvalid_q <= 1'b1;
          rstate_q <= R_RESP;
        end
        R_RESP: begin
          if (s_axi.S_AXI_RREADY) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rstate_q  <= R_IDLE;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_strobe = wr_strobe_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
endmodule

// File: tb/tb_axi4_lite_slave.sv
// Bench for axi4_lite_slave: directed corner cases plus randomized write/read traffic
// checked against a word-array reference memory and cycle-latency expectations.
module tb_axi4_lite_slave;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = DW / 8;
  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int unsigned SIZE  = 4096;
  localparam int unsigned WORDS = SIZE / 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4_lite_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  logic          wr_en, rd_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic [SW-1:0] wr_strobe;

  axi4_lite_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE), .SIZE_BYTES(SIZE)) dut (
    .clk(clk), .rst(rst), .s_axi(bus),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strobe(wr_strobe),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  // Peripheral: byte-strobed word memory, read data one cycle after rd_en (old data on collision).
  logic [31:0] pmem    [WORDS];
  logic [31:0] ref_mem [WORDS];
  initial rd_data = '0;
  always @(posedge clk) begin
    if (rd_en) rd_data <= pmem[rd_addr[11:2]];
    if (wr_en)
      for (int b = 0; b < 4; b++)
        if (wr_strobe[b]) pmem[wr_addr[11:2]][8*b +: 8] <= wr_data[8*b +: 8];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + SIZE);
  endfunction

  function automatic logic [31:0] word_off(input logic [31:0] a);
    return (a - BASE) & ~32'h3;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] off;
    off = word_off(a);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[off[11:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned sel;
    sel = $urandom_range(0, 9);
    if (sel < 6)  return BASE + $urandom_range(0, 63);
    if (sel == 6) return BASE + SIZE - 4 + $urandom_range(0, 3);
    if (sel == 7) return BASE + SIZE + $urandom_range(0, 255);
    if (sel == 8) return BASE - $urandom_range(1, 64);
    return BASE + $urandom_range(0, SIZE - 1);
  endfunction

  // Full write transaction; entered and left just after a rising edge.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
    int c, aw_cyc, w_cyc, bv_cyc, wr_cyc, wr_cnt, hs;
    bit done, ready_ok, stable_ok, payload_ok, inr;
    logic [1:0] resp0;
    logic [31:0] off;
    c = 0; aw_cyc = -1; w_cyc = -1; bv_cyc = -1; wr_cyc = -1; wr_cnt = 0;
    done = 0; ready_ok = 1; stable_ok = 1; payload_ok = 1; resp0 = 2'b01;
    inr = in_range(addr); off = word_off(addr);
    while (!done && c < 100) begin
      bus.S_AXI_AWADDR  = addr;
      bus.S_AXI_AWVALID = (aw_cyc < 0 && c >= aw_dly);
      bus.S_AXI_WDATA   = data;
      bus.S_AXI_WSTRB   = strb;
      bus.S_AXI_WVALID  = (w_cyc < 0 && c >= w_dly);
      bus.S_AXI_BREADY  = (bv_cyc >= 0) ? (c >= bv_cyc + b_dly) : (b_dly == 0);
      @(negedge clk);
      if (aw_cyc >= 0 && bus.S_AXI_AWREADY) ready_ok = 0;
      if (w_cyc >= 0 && bus.S_AXI_WREADY) ready_ok = 0;
      if (bus.S_AXI_AWVALID && bus.S_AXI_AWREADY) aw_cyc = c;
      if (bus.S_AXI_WVALID && bus.S_AXI_WREADY) w_cyc = c;
      if (wr_en) begin
        wr_cnt++; wr_cyc = c;
        if (wr_addr !== off || wr_data !== data || wr_strobe !== strb) payload_ok = 0;
      end
      if (bus.S_AXI_BVALID) begin
        if (bv_cyc < 0) begin bv_cyc = c; resp0 = bus.S_AXI_BRESP; end
        else if (bus.S_AXI_BRESP !== resp0) stable_ok = 0;
        if (bus.S_AXI_BREADY) done = 1;
      end
      @(posedge clk); #1;
      c++;
    end
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b0;
    hs = (aw_cyc > w_cyc) ? aw_cyc : w_cyc;
    check("wr_done", done, 1'b1);
    check("wr_en_count", wr_cnt, inr ? 1 : 0);
    if (inr) check("wr_en_latency", wr_cyc, hs + 1);
    check("bvalid_latency", bv_cyc, hs + 2);
    check("bresp", resp0, inr ? 2'b00 : 2'b10);
    check("wr_payload", payload_ok, 1'b1);
    check("wr_ready_low", ready_ok, 1'b1);
    check("b_stable", stable_ok, 1'b1);
    if (inr) ref_write(addr, data, strb);
  endtask

  // Full read transaction; expected data comes from the reference memory.
  task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int r_dly);
    int c, ar_cyc, rv_cyc, rd_cyc, rd_cnt;
    bit done, ready_ok, stable_ok, addr_ok, inr;
    logic [1:0] resp0;
    logic [31:0] data0, off, exp_d;
    c = 0; ar_cyc = -1; rv_cyc = -1; rd_cyc = -1; rd_cnt = 0;
    done = 0; ready_ok = 1; stable_ok = 1; addr_ok = 1; resp0 = 2'b01; data0 = '0;
    inr = in_range(addr); off = word_off(addr);
    exp_d = inr ? ref_mem[off[11:2]] : 32'h0;
    while (!done && c < 100) begin
      bus.S_AXI_ARADDR  = addr;
      bus.S_AXI_ARVALID = (ar_cyc < 0 && c >= ar_dly);
      bus.S_AXI_RREADY  = (rv_cyc >= 0) ? (c >= rv_cyc + r_dly) : (r_dly == 0);
      @(negedge clk);
      if (ar_cyc >= 0 && bus.S_AXI_ARREADY) ready_ok = 0;
      if (bus.S_AXI_ARVALID && bus.S_AXI_ARREADY) ar_cyc = c;
      if (rd_en) begin
        rd_cnt++; rd_cyc = c;
        if (rd_addr !== off) addr_ok = 0;
      end
      if (bus.S_AXI_RVALID) begin
        if (rv_cyc < 0) begin rv_cyc = c; resp0 = bus.S_AXI_RRESP; data0 = bus.S_AXI_RDATA; end
        else if (bus.S_AXI_RRESP !== resp0 || bus.S_AXI_RDATA !== data0) stable_ok = 0;
        if (bus.S_AXI_RREADY) done = 1;
      end
      @(posedge clk); #1;
      c++;
    end
    bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
    check("rd_done", done, 1'b1);
    check("rd_en_count", rd_cnt, inr ? 1 : 0);
    if (inr) check("rd_en_latency", rd_cyc, ar_cyc + 1);
    check("rvalid_latency", rv_cyc, ar_cyc + 3);
    check("rdata", data0, exp_d);
    check("rresp", resp0, inr ? 2'b00 : 2'b10);
    check("rd_addr", addr_ok, 1'b1);
    check("rd_ready_low", ready_ok, 1'b1);
    check("r_stable", stable_ok, 1'b1);
  endtask

  initial begin
    bit quiet;
    for (int i = 0; i < WORDS; i++) begin pmem[i] = '0; ref_mem[i] = '0; end
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WDATA = '0;
    bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;

    #2 rst = 1'b0;
    #1;
    check("rst_awready", bus.S_AXI_AWREADY, 1'b0);
    check("rst_wready", bus.S_AXI_WREADY, 1'b0);
    check("rst_arready", bus.S_AXI_ARREADY, 1'b0);
    check("rst_bvalid", bus.S_AXI_BVALID, 1'b0);
    check("rst_rvalid", bus.S_AXI_RVALID, 1'b0);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_rdata", bus.S_AXI_RDATA, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_awready", bus.S_AXI_AWREADY, 1'b1);
    check("post_rst_wready", bus.S_AXI_WREADY, 1'b1);
    check("post_rst_arready", bus.S_AXI_ARREADY, 1'b1);

    axi_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    axi_write(BASE + 32'h20, 32'h1234_5678, 4'hF, 3, 0, 0);
    axi_read (BASE + 32'h10, 0, 0);
    check("readback_deadbeef", ref_mem[4], 32'hDEAD_BEEF);
    axi_write(BASE + SIZE, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
    axi_read (BASE + SIZE, 0, 0);
    axi_write(BASE + 32'h13, 32'hA5A5_0000, 4'b1100, 1, 2, 10);
    axi_read (BASE + 32'h10, 0, 10);

    // Reset with a write parked in W_RESP and a read in R_WAIT.
    bus.S_AXI_AWADDR = BASE + 32'h40; bus.S_AXI_WDATA = 32'h0BAD_C0DE; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b0;
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_bvalid", bus.S_AXI_BVALID, 1'b1);
    ref_write(BASE + 32'h40, 32'h0BAD_C0DE, 4'hF);
    bus.S_AXI_ARADDR = BASE + 32'h40; bus.S_AXI_ARVALID = 1'b1;
    @(posedge clk); #1;
    bus.S_AXI_ARVALID = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("rst_mid_bvalid", bus.S_AXI_BVALID, 1'b0);
    check("rst_mid_rvalid", bus.S_AXI_RVALID, 1'b0);
    check("rst_mid_awready", bus.S_AXI_AWREADY, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("rel_awready", bus.S_AXI_AWREADY, 1'b1);
    check("rel_wready", bus.S_AXI_WREADY, 1'b1);
    check("rel_arready", bus.S_AXI_ARREADY, 1'b1);
    bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
    quiet = 1;
    repeat (4) begin
      @(negedge clk);
      if (bus.S_AXI_BVALID || bus.S_AXI_RVALID) quiet = 0;
    end
    @(posedge clk); #1;
    bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
    check("no_stale_response", quiet, 1'b1);
    axi_write(BASE + 32'h44, 32'h7777_1111, 4'hF, 0, 0, 0);
    axi_read (BASE + 32'h40, 0, 0);
    axi_read (BASE + 32'h44, 1, 2);

    for (int i = 0; i < 40; i++) begin
      axi_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4));
      axi_read(rand_addr(), $urandom_range(0, 3), $urandom_range(0, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
